// File: rtl/sweep_pkg.sv
// Shared types for the SDRAM sweep responder: FSM state encoding and data width.
package sweep_pkg;
    localparam int DATA_W = 16;

    typedef enum logic [2:0] {
        ST_INIT     = 3'd0,
        ST_IDLE     = 3'd1,
        ST_WRITE    = 3'd2,
        ST_RD_ISSUE = 3'd3,
        ST_RD_DATA  = 3'd4,
        ST_GAP      = 3'd5,
        ST_FINISH   = 3'd6
    } state_e;

    // Beat states are the only ones in which ready is driven high.
    function automatic logic is_beat(input state_e s);
        return (s == ST_WRITE) || (s == ST_RD_DATA);
    endfunction
endpackage

// File: rtl/sweep_bram.sv
// Simple dual-port block RAM: one write port, one read port with a registered output.
module sweep_bram
    import sweep_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] rdata_q;

    // Write port; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read port; output register holds between reads.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/sdram_sweep_responder.sv
// Stand-in for the SDRAM controller: answers the tester's start/rnw/done/ready sweeps
// from a block-RAM image, with optional single-bit read fault injection.
module sdram_sweep_responder
    import sweep_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int INIT_CYCLES = 16,
    parameter int READY_GAP   = 1,
    parameter int FAULT_ADDR  = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              rnw_i,
    input  logic              fault_en_i,
    input  logic [DATA_W-1:0] wdat_i,
    output logic              done_o,
    output logic              ready_o,
    output logic [DATA_W-1:0] rdat_o
);
    localparam int INIT_W    = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam int INIT_LAST = (INIT_CYCLES > 0) ? INIT_CYCLES - 1 : 0;
    localparam int GAP_W     = (READY_GAP > 1) ? $clog2(READY_GAP) : 1;
    localparam int GAP_LAST  = (READY_GAP > 0) ? READY_GAP - 1 : 0;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [INIT_W-1:0] init_q, init_d;
    logic              rnw_q, rnw_d;
    logic              fault_q, fault_d;
    logic              ready_q, ready_d;
    logic              done_q, done_d;
    logic              we_s, re_s;
    logic [DATA_W-1:0] rdata_s;

    // State and datapath registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_INIT;
            addr_q  <= '0;
            gap_q   <= '0;
            init_q  <= '0;
            rnw_q   <= 1'b0;
            fault_q <= 1'b0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            gap_q   <= gap_d;
            init_q  <= init_d;
            rnw_q   <= rnw_d;
            fault_q <= fault_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    // Next-state and counter logic.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        gap_d   = gap_q;
        init_d  = init_q;
        rnw_d   = rnw_q;
        case (state_q)
            ST_INIT: begin
                if (init_q == INIT_W'(INIT_LAST)) begin
                    state_d = ST_IDLE;
                end else begin
                    init_d = init_q + INIT_W'(1);
                end
            end
            ST_IDLE: begin
                if (start_i) begin
                    rnw_d   = rnw_i;
                    addr_d  = '0;
                    gap_d   = '0;
                    state_d = rnw_i ? ST_RD_ISSUE : ST_WRITE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE, ST_RD_DATA: begin
                // Stop at the top address so a sweep never wraps.
                if (addr_q == {ADDR_W{1'b1}}) begin
                    state_d = ST_FINISH;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                    gap_d  = '0;
                    if (READY_GAP > 0) begin
                        state_d = ST_GAP;
                    end else begin
                        state_d = rnw_q ? ST_RD_ISSUE : ST_WRITE;
                    end
                end
            end
            ST_RD_ISSUE: state_d = ST_RD_DATA;
            ST_GAP: begin
                if (gap_q == GAP_W'(GAP_LAST)) begin
                    state_d = rnw_q ? ST_RD_ISSUE : ST_WRITE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_INIT;
        endcase
    end

    // Output decode; ready/done are registered from the next state.
    always_comb begin
        we_s    = (state_q == ST_WRITE);
        re_s    = (state_q == ST_RD_ISSUE);
        ready_d = is_beat(state_d);
        done_d  = (state_d == ST_IDLE);
        if (re_s) begin
            fault_d = fault_en_i && (addr_q == ADDR_W'(FAULT_ADDR));
        end else begin
            fault_d = fault_q;
        end
    end

    sweep_bram #(
        .ADDR_W (ADDR_W)
    ) u_bram (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (we_s),
        .waddr_i (addr_q),
        .wdata_i (wdat_i),
        .re_i    (re_s),
        .raddr_i (addr_q),
        .rdata_o (rdata_s)
    );

    assign ready_o = ready_q;
    assign done_o  = done_q;
    assign rdat_o  = rdata_s ^ {{(DATA_W-1){1'b0}}, fault_q};
endmodule
